// File: rtl/bus_fabric.sv
// bus_fabric: registered single-outstanding-transaction interconnect between
// the CPU data port and N_SLAVES address-decoded slave regions. Adds per-slave
// ready handshakes, a wait-state watchdog and bus-error reporting.

// Per-slot address matcher; one instance per slave region.
module bus_fabric_slot #(
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] MASK   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);
    assign hit = ((addr & MASK) == BASE);
endmodule

module bus_fabric #(
    parameter int                           N_SLAVES   = 3,
    parameter int                           ADDR_W     = 16,
    parameter int                           DATA_W     = 8,
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_BASE = {16'h2000, 16'h1000, 16'h0000},
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_MASK = {16'hF000, 16'hFF00, 16'hF800},
    parameter int                           TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            m_address,
    input  logic [DATA_W-1:0]            m_din,
    input  logic                         m_w_en,
    input  logic                         m_r_en,
    output logic [DATA_W-1:0]            m_dout,
    output logic                         m_ready,
    output logic                         m_err,
    output logic                         m_busy,
    output logic [N_SLAVES-1:0]          s_sel,
    output logic [ADDR_W-1:0]            s_address,
    output logic [DATA_W-1:0]            s_din,
    output logic                         s_w_en,
    output logic                         s_r_en,
    input  logic [N_SLAVES*DATA_W-1:0]   s_dout,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic [ADDR_W-1:0]            err_addr,
    output logic                         err_irq
);

    // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so widths stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state;
    logic                   lat_wr;
    logic                   err_pend;
    logic [CNT_W-1:0]       wait_cnt;
    logic [N_SLAVES-1:0]    hit_vec;
    logic [N_SLAVES-1:0]    hit_onehot;
    logic [DATA_W-1:0]      rd_data;
    logic                   ready_sel;
    logic                   wd_expired;

    genvar g;
    generate
        for (g = 0; g < N_SLAVES; g++) begin : g_slot
            bus_fabric_slot #(
                .ADDR_W (ADDR_W),
                .BASE   (SLAVE_BASE[g*ADDR_W +: ADDR_W]),
                .MASK   (SLAVE_MASK[g*ADDR_W +: ADDR_W])
            ) u_slot (
                .addr (m_address),
                .hit  (hit_vec[g])
            );
        end
    endgenerate

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
    assign hit_onehot = hit_vec & (~hit_vec + N_SLAVES'(1));

    // Read-data and ready select driven by the registered one-hot s_sel.
    always_comb begin
        rd_data   = '0;
        ready_sel = |(s_ready & s_sel);
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_sel[i]) rd_data = rd_data | s_dout[i*DATA_W +: DATA_W];
        end
    end

    assign wd_expired = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

    // Main transaction FSM; all bus outputs are registered here.
    // Errors spend one silent cycle in RESP (err_pend) before m_ready/m_err/err_irq
    // are raised together, so error responses land one cycle later than successes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_wr    <= 1'b0;
            err_pend  <= 1'b0;
            wait_cnt  <= '0;
            m_dout    <= '0;
            m_ready   <= 1'b0;
            m_err     <= 1'b0;
            m_busy    <= 1'b0;
            s_sel     <= '0;
            s_address <= '0;
            s_din     <= '0;
            s_w_en    <= 1'b0;
            s_r_en    <= 1'b0;
            err_addr  <= '0;
            err_irq   <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            err_irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_w_en || m_r_en) begin
                        s_address <= m_address;
                        s_din     <= m_din;
                        lat_wr    <= m_w_en;
                        m_busy    <= 1'b1;
                        if (|hit_vec) begin
                            s_sel    <= hit_onehot;
                            s_w_en   <= m_w_en;
                            s_r_en   <= ~m_w_en;
                            wait_cnt <= '0;
                            state    <= ACCESS;
                        end else begin
                            err_pend <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (ready_sel) begin
                        m_dout  <= lat_wr ? '0 : rd_data;
                        s_sel   <= '0;
                        s_w_en  <= 1'b0;
                        s_r_en  <= 1'b0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        state   <= RESP;
                    end else if (wd_expired) begin
                        s_sel    <= '0;
                        s_w_en   <= 1'b0;
                        s_r_en   <= 1'b0;
                        err_pend <= 1'b1;
                        state    <= RESP;
                    end else if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (err_pend) begin
                        err_pend <= 1'b0;
                        m_ready  <= 1'b1;
                        m_err    <= 1'b1;
                        err_irq  <= 1'b1;
                        err_addr <= s_address;
                        m_dout   <= '0;
                    end else begin
                        m_err  <= 1'b0;
                        m_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: hit read, waited write, unmapped, timeout,
// overlap priority, address boundaries, busy rejection and mid-access reset.
module tb_bus_fabric;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] m_address = '0;
    logic [7:0]  m_din = '0;
    logic        m_w_en = 1'b0;
    logic        m_r_en = 1'b0;
    logic [7:0]  m_dout;
    logic        m_ready, m_err, m_busy;
    logic [2:0]  s_sel;
    logic [15:0] s_address;
    logic [7:0]  s_din;
    logic        s_w_en, s_r_en;
    logic [23:0] s_dout = '0;
    logic [2:0]  s_ready = '0;
    logic [15:0] err_addr;
    logic        err_irq;

    // Second instance with slots 0 and 1 both covering 0x1000.
    logic [15:0] ov_address = '0;
    logic        ov_r_en = 1'b0;
    logic [7:0]  ov_m_dout;
    logic        ov_m_ready, ov_m_err, ov_m_busy;
    logic [2:0]  ov_s_sel;
    logic [15:0] ov_s_address;
    logic [7:0]  ov_s_din;
    logic        ov_s_w_en, ov_s_r_en;
    logic [15:0] ov_err_addr;
    logic        ov_err_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_fabric dut (
        .clk(clk), .rst(rst), .m_address(m_address), .m_din(m_din),
        .m_w_en(m_w_en), .m_r_en(m_r_en), .m_dout(m_dout), .m_ready(m_ready),
        .m_err(m_err), .m_busy(m_busy), .s_sel(s_sel), .s_address(s_address),
        .s_din(s_din), .s_w_en(s_w_en), .s_r_en(s_r_en), .s_dout(s_dout),
        .s_ready(s_ready), .err_addr(err_addr), .err_irq(err_irq)
    );

    bus_fabric #(.SLAVE_BASE({16'h2000, 16'h1000, 16'h1000})) dut_ov (
        .clk(clk), .rst(rst), .m_address(ov_address), .m_din(8'h00),
        .m_w_en(1'b0), .m_r_en(ov_r_en), .m_dout(ov_m_dout), .m_ready(ov_m_ready),
        .m_err(ov_m_err), .m_busy(ov_m_busy), .s_sel(ov_s_sel), .s_address(ov_s_address),
        .s_din(ov_s_din), .s_w_en(ov_s_w_en), .s_r_en(ov_s_r_en),
        .s_dout({8'h33, 8'h22, 8'h11}), .s_ready(3'b111),
        .err_addr(ov_err_addr), .err_irq(ov_err_irq)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int   r_cnt, ready_at;
    logic err_seen, irq_seen, any_rdy;
    logic [15:0] ea_seen;
    logic [7:0]  dout_seen;

    initial begin
        // Reset state
        tick; tick;
        check("rst_outs", {m_dout, m_ready, m_err, m_busy, s_sel, s_w_en, s_r_en, err_irq}, '0);
        check("rst_addr", {s_address, s_din, err_addr}, '0);
        rst = 1'b1;
        tick;

        // Read 0x0123, slave0 ready immediately
        s_dout = {8'h00, 8'h00, 8'h5A}; s_ready = 3'b001;
        m_address = 16'h0123; m_r_en = 1'b1;
        tick; m_r_en = 1'b0;
        check("rd_sel",    {s_sel, s_r_en, s_w_en, m_busy, m_ready}, {3'b001, 1'b1, 1'b0, 1'b1, 1'b0});
        tick;
        check("rd_resp",   {s_sel, m_ready, m_err, m_dout}, {3'b000, 1'b1, 1'b0, 8'h5A});
        tick;
        check("rd_idle",   {m_ready, m_busy}, 2'b00);

        // Write 0x1005 = 0xC3, slave1 ready after 3 wait cycles
        s_ready = 3'b000;
        m_address = 16'h1005; m_din = 8'hC3; m_w_en = 1'b1;
        tick; m_w_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wr_hold", {s_sel, s_w_en, s_r_en, s_din, m_ready}, {3'b010, 1'b1, 1'b0, 8'hC3, 1'b0});
            if (k == 3) s_ready = 3'b010;
            tick;
        end
        check("wr_resp", {s_sel, s_w_en, m_ready, m_err, m_dout}, {3'b000, 1'b0, 1'b1, 1'b0, 8'h00});
        s_ready = 3'b000;
        tick;

        // Unmapped read 0x9000
        m_address = 16'h9000; m_r_en = 1'b1;
        tick; m_r_en = 1'b0;
        check("um_t1", {s_sel, s_r_en, s_w_en, m_ready, m_busy}, {3'b000, 1'b0, 1'b0, 1'b0, 1'b1});
        tick;
        check("um_t2", {s_sel, s_r_en, m_ready, m_err, err_irq, m_dout}, {3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00});
        check("um_addr", err_addr, 16'h9000);
        tick;
        check("um_after", {m_ready, err_irq, m_busy}, 3'b000);

        // Timeout: read 0x2400, slave2 never ready
        s_dout = {8'h77, 8'h00, 8'h00}; s_ready = 3'b000;
        r_cnt = 0; ready_at = 0; err_seen = 0; irq_seen = 0; ea_seen = '0; dout_seen = 8'hFF;
        m_address = 16'h2400; m_r_en = 1'b1;
        tick; m_r_en = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (s_r_en) r_cnt++;
            if (m_ready && ready_at == 0) begin
                ready_at = c; err_seen = m_err; irq_seen = err_irq; ea_seen = err_addr; dout_seen = m_dout;
            end
            if (ready_at == 0) tick;
        end
        check("to_strobe_cycles", r_cnt, 16);
        check("to_latency", ready_at, 18);
        check("to_err", {err_seen, irq_seen, dout_seen}, {1'b1, 1'b1, 8'h00});
        check("to_addr", ea_seen, 16'h2400);
        tick;

        // 0x07FF hits slot 0; request during busy is ignored
        s_dout = {8'h00, 8'h00, 8'hA5}; s_ready = 3'b000;
        m_address = 16'h07FF; m_r_en = 1'b1;
        tick; m_r_en = 1'b0;
        check("bnd_07ff", {s_sel, s_r_en}, {3'b001, 1'b1});
        m_address = 16'h1005; m_din = 8'h11; m_w_en = 1'b1;
        tick; m_w_en = 1'b0;
        check("busy_ign", {s_sel, s_r_en, s_w_en, s_address}, {3'b001, 1'b1, 1'b0, 16'h07FF});
        s_ready = 3'b001;
        tick;
        check("busy_resp", {m_ready, m_err, m_dout}, {1'b1, 1'b0, 8'hA5});
        tick;
        check("busy_idle", {m_busy, s_sel, m_ready}, {1'b0, 3'b000, 1'b0});
        tick;
        check("busy_noqueue", {m_busy, s_sel}, {1'b0, 3'b000});
        s_ready = 3'b000;

        // 0x0800 is unmapped
        m_address = 16'h0800; m_r_en = 1'b1;
        tick; m_r_en = 1'b0;
        check("bnd_0800_sel", {s_sel, s_r_en}, {3'b000, 1'b0});
        tick;
        check("bnd_0800_err", {m_ready, m_err, err_addr}, {1'b1, 1'b1, 16'h0800});
        tick;

        // Overlap: slots 0 and 1 both match 0x1000, lowest wins
        ov_address = 16'h1000; ov_r_en = 1'b1;
        tick; ov_r_en = 1'b0;
        check("ov_sel", ov_s_sel, 3'b001);
        tick;
        check("ov_resp", {ov_m_ready, ov_m_err, ov_m_dout}, {1'b1, 1'b0, 8'h11});
        tick;

        // Reset during ACCESS
        s_ready = 3'b000;
        m_address = 16'h0123; m_r_en = 1'b1;
        tick; m_r_en = 1'b0;
        check("rm_access", s_sel, 3'b001);
        rst = 1'b0;
        #1;
        check("rm_async", {s_sel, s_r_en, s_w_en, m_busy}, '0);
        tick; tick;
        rst = 1'b1;
        any_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            any_rdy = any_rdy | m_ready;
        end
        check("rm_no_ready", {any_rdy, m_busy}, 2'b00);
        s_dout = {8'h00, 8'h00, 8'h3C}; s_ready = 3'b001;
        m_address = 16'h0123; m_r_en = 1'b1;
        tick; m_r_en = 1'b0;
        tick;
        check("rm_new_read", {m_ready, m_err, m_dout}, {1'b1, 1'b0, 8'h3C});
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
